// File: rtl/qpsk_frame_source.sv
// Framed QPSK symbol source: preamble, sync word and PN payload on I/Q,
// one symbol every SPS clocks with strobe, phase and frame markers.
module qpsk_frame_source #(
   parameter int unsigned SPS       = 8,
   parameter int unsigned PRE_LEN   = 16,
   parameter int unsigned SYNC_LEN  = 16,
   parameter logic [31:0] SYNC_WORD = 32'h0000_F35A,
   parameter int unsigned PAY_LEN   = 256,
   parameter logic [12:0] GEN_POLY  = 13'b1_0000_1101_0001,
   parameter logic [11:0] SEED_I    = 12'h001,
   parameter logic [11:0] SEED_Q    = 12'h003
) (
   input  logic                     clock_5000,
   input  logic                     reset,
   input  logic                     enable,
   output logic                     sym_i,
   output logic                     sym_q,
   output logic                     sym_strobe,
   output logic [$clog2(SPS)-1:0]   sym_phase,
   output logic                     frame_start,
   output logic                     busy
);

   localparam int unsigned PW   = $clog2(SPS);
   localparam int unsigned MAX1 = (PRE_LEN > SYNC_LEN) ? PRE_LEN : SYNC_LEN;
   localparam int unsigned MAXL = (MAX1 > PAY_LEN) ? MAX1 : PAY_LEN;
   localparam int unsigned CW   = $clog2(MAXL + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRE,
      S_SYNC,
      S_PAY
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   phase_q, phase_d;
   logic [11:0]     li_q, li_d;
   logic [11:0]     lq_q, lq_d;
   logic            si_q, si_d;
   logic            sq_q, sq_d;
   logic            stb_q, stb_d;
   logic            fs_q, fs_d;
   logic            busy_q, busy_d;

   logic            wrap;
   logic [CW-1:0]   cnt_n;
   logic [4:0]      sidx;

   function automatic logic [11:0] lfsr_step(input logic [11:0] v);
      return {v[10:0], 1'b0} ^ (v[11] ? GEN_POLY[11:0] : 12'h000);
   endfunction

   assign wrap  = (phase_q == PW'(SPS - 1));
   assign cnt_n = cnt_q + CW'(1);
   assign sidx  = 5'(SYNC_LEN - 1) - 5'(cnt_n);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      li_d    = li_q;
      lq_d    = lq_q;
      si_d    = si_q;
      sq_d    = sq_q;
      stb_d   = 1'b0;
      fs_d    = 1'b0;
      busy_d  = busy_q;
      unique case (state_q)
         S_IDLE: begin
            si_d    = 1'b0;
            sq_d    = 1'b0;
            phase_d = '0;
            busy_d  = 1'b0;
            if (enable) begin
               state_d = S_PRE;
               cnt_d   = '0;
               si_d    = 1'b1;
               stb_d   = 1'b1;
               fs_d    = 1'b1;
               busy_d  = 1'b1;
            end
         end
         S_PRE: begin
            phase_d = phase_q + PW'(1);
            if (wrap) begin
               phase_d = '0;
               stb_d   = 1'b1;
               if (cnt_q == CW'(PRE_LEN - 1)) begin
                  state_d = S_SYNC;
                  cnt_d   = '0;
                  si_d    = SYNC_WORD[SYNC_LEN-1];
                  sq_d    = SYNC_WORD[SYNC_LEN-1];
               end else begin
                  cnt_d = cnt_n;
                  si_d  = ~cnt_n[0];
                  sq_d  = cnt_n[0];
               end
            end
         end
         S_SYNC: begin
            phase_d = phase_q + PW'(1);
            if (wrap) begin
               phase_d = '0;
               stb_d   = 1'b1;
               if (cnt_q == CW'(SYNC_LEN - 1)) begin
                  state_d = S_PAY;
                  cnt_d   = '0;
                  si_d    = li_q[11];
                  sq_d    = lq_q[11];
                  li_d    = lfsr_step(li_q);
                  lq_d    = lfsr_step(lq_q);
               end else begin
                  cnt_d = cnt_n;
                  si_d  = SYNC_WORD[sidx];
                  sq_d  = SYNC_WORD[sidx];
               end
            end
         end
         S_PAY: begin
            phase_d = phase_q + PW'(1);
            if (wrap) begin
               phase_d = '0;
               stb_d   = 1'b1;
               if (cnt_q == CW'(PAY_LEN - 1)) begin
                  // seeds reload so every frame repeats the same payload
                  li_d  = SEED_I;
                  lq_d  = SEED_Q;
                  cnt_d = '0;
                  if (enable) begin
                     state_d = S_PRE;
                     si_d    = 1'b1;
                     sq_d    = 1'b0;
                     fs_d    = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                     si_d    = 1'b0;
                     sq_d    = 1'b0;
                     stb_d   = 1'b0;
                     busy_d  = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_n;
                  si_d  = li_q[11];
                  sq_d  = lq_q[11];
                  li_d  = lfsr_step(li_q);
                  lq_d  = lfsr_step(lq_q);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock_5000) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         phase_q <= '0;
         li_q    <= SEED_I;
         lq_q    <= SEED_Q;
         si_q    <= 1'b0;
         sq_q    <= 1'b0;
         stb_q   <= 1'b0;
         fs_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         li_q    <= li_d;
         lq_q    <= lq_d;
         si_q    <= si_d;
         sq_q    <= sq_d;
         stb_q   <= stb_d;
         fs_q    <= fs_d;
         busy_q  <= busy_d;
      end
   end

   assign sym_i       = si_q;
   assign sym_q       = sq_q;
   assign sym_strobe  = stb_q;
   assign sym_phase   = phase_q;
   assign frame_start = fs_q;
   assign busy        = busy_q;

endmodule
